// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode, ALUOp and control-bundle definitions for the ID-stage control path.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    typedef struct packed {
        logic       ALUSrc;
        logic       MemRead;
        logic       MemWrite;
        logic       RegWrite;
        logic       MemtoReg;
        logic       Branch;
        logic [1:0] ALUOp;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(8'h00);

    // Instructions whose rs2 field names a real source register.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/id_ex_ctrl_stage_decode.sv
// Combinational opcode decoder producing the control bundle and the illegal flag.
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic       valid,
    output ctrl_t      ctrl,
    output logic       illegal
);

    // Opcode to control-bundle table; unknown opcodes only flag when the slot is real.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = ALU_FN;
            end
            OP_IMM: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.ALUOp    = ALU_FN;
            end
            OP_LOAD: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.MemRead  = 1'b1;
                ctrl.RegWrite = 1'b1;
                ctrl.MemtoReg = 1'b1;
                ctrl.ALUOp    = ALU_ADD;
            end
            OP_STORE: begin
                ctrl.ALUSrc   = 1'b1;
                ctrl.MemWrite = 1'b1;
                ctrl.ALUOp    = ALU_ADD;
            end
            OP_BRANCH: begin
                ctrl.Branch = 1'b1;
                ctrl.ALUOp  = ALU_BR;
            end
            default: begin
                ctrl    = CTRL_BUBBLE;
                illegal = valid;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID stage: decode, load-use detection and the ID/EX control register with a
// saturating count of inserted bubbles.
module id_ex_ctrl_stage
    import riscv_ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    if_id_instr,
    input  logic                  if_id_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  illegal,
    output logic                  id_ex_valid,
    output logic [1:0]            id_ex_ALUOp,
    output logic [3:0]            id_ex_Funct,
    output logic                  id_ex_ALUSrc,
    output logic                  id_ex_MemRead,
    output logic                  id_ex_MemWrite,
    output logic                  id_ex_RegWrite,
    output logic                  id_ex_MemtoReg,
    output logic                  id_ex_Branch,
    output logic [REG_ADDR_W-1:0] id_ex_rs1,
    output logic [REG_ADDR_W-1:0] id_ex_rs2,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [CNT_W-1:0]      bubble_count
);

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

    logic [6:0]            opcode_s;
    logic [REG_ADDR_W-1:0] rs1_s;
    logic [REG_ADDR_W-1:0] rs2_s;
    logic [REG_ADDR_W-1:0] rd_s;
    logic [3:0]            funct_s;
    ctrl_t                 dec_ctrl_s;
    logic                  dec_illegal_s;
    logic                  hazard_s;
    logic                  insert_bubble_s;

    ctrl_t                 ctrl_r;
    logic                  valid_r;
    logic [3:0]            funct_r;
    logic [REG_ADDR_W-1:0] rs1_r;
    logic [REG_ADDR_W-1:0] rs2_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [CNT_W-1:0]      count_r;

    assign opcode_s = if_id_instr[6:0];
    assign rs1_s    = if_id_instr[15 +: REG_ADDR_W];
    assign rs2_s    = if_id_instr[20 +: REG_ADDR_W];
    assign rd_s     = if_id_instr[7 +: REG_ADDR_W];

    ctrl_decode u_decode (
        .opcode  (opcode_s),
        .valid   (if_id_valid),
        .ctrl    (dec_ctrl_s),
        .illegal (dec_illegal_s)
    );

    // Only R-type carries the add/sub selector; in I-arith bit 30 is immediate data.
    always_comb begin
        if (opcode_s == OP_R) begin
            funct_s = {if_id_instr[30], if_id_instr[14:12]};
        end else begin
            funct_s = {1'b0, if_id_instr[14:12]};
        end
    end

    // Load-use compare against the load currently sitting in ID/EX.
    always_comb begin
        hazard_s = 1'b0;
        if (if_id_valid && valid_r && ctrl_r.MemRead && (rd_r != REG_ZERO)) begin
            hazard_s = (rd_r == rs1_s) || ((rd_r == rs2_s) && uses_rs2(opcode_s));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign insert_bubble_s = hazard_s || dec_illegal_s;
    assign hazard_stall    = hazard_s;
    assign illegal         = dec_illegal_s;

    // ID/EX register: reset > flush > stall hold > hazard/illegal bubble > load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_r  <= CTRL_BUBBLE;
            valid_r <= 1'b0;
            funct_r <= 4'h0;
            rs1_r   <= REG_ZERO;
            rs2_r   <= REG_ZERO;
            rd_r    <= REG_ZERO;
            count_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            ctrl_r  <= CTRL_BUBBLE;
            valid_r <= 1'b0;
            funct_r <= 4'h0;
            rs1_r   <= REG_ZERO;
            rs2_r   <= REG_ZERO;
            rd_r    <= REG_ZERO;
        end else if (stall) begin
            ctrl_r  <= ctrl_r;
            valid_r <= valid_r;
        end else if (insert_bubble_s || !if_id_valid) begin
            ctrl_r  <= CTRL_BUBBLE;
            valid_r <= 1'b0;
            funct_r <= 4'h0;
            rs1_r   <= REG_ZERO;
            rs2_r   <= REG_ZERO;
            rd_r    <= REG_ZERO;
            if (insert_bubble_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ctrl_r  <= dec_ctrl_s;
            valid_r <= 1'b1;
            funct_r <= funct_s;
            rs1_r   <= rs1_s;
            rs2_r   <= rs2_s;
            rd_r    <= rd_s;
        end
    end

    assign id_ex_valid    = valid_r;
    assign id_ex_ALUOp    = ctrl_r.ALUOp;
    assign id_ex_Funct    = funct_r;
    assign id_ex_ALUSrc   = ctrl_r.ALUSrc;
    assign id_ex_MemRead  = ctrl_r.MemRead;
    assign id_ex_MemWrite = ctrl_r.MemWrite;
    assign id_ex_RegWrite = ctrl_r.RegWrite;
    assign id_ex_MemtoReg = ctrl_r.MemtoReg;
    assign id_ex_Branch   = ctrl_r.Branch;
    assign id_ex_rs1      = rs1_r;
    assign id_ex_rs2      = rs2_r;
    assign id_ex_rd       = rd_r;
    assign bubble_count   = count_r;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Bench for id_ex_ctrl_stage: a behavioural model checked every cycle plus
// hand-computed expectations for the directed instruction sequence.
module tb_id_ex_ctrl_stage;

    logic        clk = 1'b0;
    logic        reset, if_id_valid, stall, flush;
    logic [31:0] if_id_instr;
    logic        hazard_stall, illegal, id_ex_valid;
    logic [1:0]  id_ex_ALUOp;
    logic [3:0]  id_ex_Funct;
    logic        id_ex_ALUSrc, id_ex_MemRead, id_ex_MemWrite, id_ex_RegWrite, id_ex_MemtoReg, id_ex_Branch;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [15:0] bubble_count;

    int checks = 0;
    int errors = 0;

    id_ex_ctrl_stage dut (
        .clk(clk), .reset(reset), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .stall(stall), .flush(flush), .hazard_stall(hazard_stall), .illegal(illegal),
        .id_ex_valid(id_ex_valid), .id_ex_ALUOp(id_ex_ALUOp), .id_ex_Funct(id_ex_Funct),
        .id_ex_ALUSrc(id_ex_ALUSrc), .id_ex_MemRead(id_ex_MemRead), .id_ex_MemWrite(id_ex_MemWrite),
        .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemtoReg(id_ex_MemtoReg), .id_ex_Branch(id_ex_Branch),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Model of the ID/EX contents: one 8-bit control word {ALUSrc,MemRead,MemWrite,RegWrite,MemtoReg,Branch,ALUOp}.
    logic        m_valid = 1'b0;
    logic [7:0]  m_ctrl  = 8'h00;
    logic [3:0]  m_funct = 4'h0;
    logic [14:0] m_regs  = 15'h0000;
    int          m_cnt   = 0;

    // Control-word table straight from the opcode list; -1 marks an unsupported opcode.
    function automatic int ctrl_of(input logic [6:0] op);
        case (op)
            7'b0110011: return 32'h12;
            7'b0010011: return 32'h92;
            7'b0000011: return 32'hD8;
            7'b0100011: return 32'hA0;
            7'b1100011: return 32'h05;
            default:    return -1;
        endcase
    endfunction

    function automatic logic m_illegal();
        return if_id_valid && (ctrl_of(if_id_instr[6:0]) < 0);
    endfunction

    function automatic logic m_hazard();
        logic [4:0] rd;
        logic       rs2_used;
        rd       = m_regs[4:0];
        rs2_used = (if_id_instr[6:0] == 7'b0110011) || (if_id_instr[6:0] == 7'b0100011)
                   || (if_id_instr[6:0] == 7'b1100011);
        return if_id_valid && m_valid && m_ctrl[6] && (rd != 5'd0) &&
               ((rd == if_id_instr[19:15]) || (rs2_used && (rd == if_id_instr[24:20])));
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0; m_ctrl <= 8'h00; m_funct <= 4'h0; m_regs <= 15'h0000; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 1'b0; m_ctrl <= 8'h00; m_funct <= 4'h0; m_regs <= 15'h0000;
        end else if (stall) begin
            m_valid <= m_valid;
        end else if (m_hazard() || m_illegal() || !if_id_valid) begin
            m_valid <= 1'b0; m_ctrl <= 8'h00; m_funct <= 4'h0; m_regs <= 15'h0000;
            if ((m_hazard() || m_illegal()) && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end else begin
            m_valid <= 1'b1;
            m_ctrl  <= 8'(ctrl_of(if_id_instr[6:0]));
            m_funct <= (if_id_instr[6:0] == 7'b0110011) ? {if_id_instr[30], if_id_instr[14:12]}
                                                        : {1'b0, if_id_instr[14:12]};
            m_regs  <= {if_id_instr[19:15], if_id_instr[24:20], if_id_instr[11:7]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        check("valid", 32'(id_ex_valid), 32'(m_valid));
        check("ctrl", 32'({id_ex_ALUSrc, id_ex_MemRead, id_ex_MemWrite, id_ex_RegWrite,
                           id_ex_MemtoReg, id_ex_Branch, id_ex_ALUOp}), 32'(m_ctrl));
        check("funct", 32'(id_ex_Funct), 32'(m_funct));
        check("regs", 32'({id_ex_rs1, id_ex_rs2, id_ex_rd}), 32'(m_regs));
        check("count", 32'(bubble_count), 32'(m_cnt));
        check("hazard", 32'(hazard_stall), 32'(m_hazard()));
        check("illegal", 32'(illegal), 32'(m_illegal()));
    end

    task automatic step(input logic [31:0] instr, input logic v, input logic s, input logic f);
        if_id_instr = instr; if_id_valid = v; stall = s; flush = f;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SUB  = 32'h402081B3;
    localparam logic [31:0] BEQ  = 32'h00208063;
    localparam logic [31:0] BLT  = 32'h0020C063;
    localparam logic [31:0] ADDI = 32'hFFF00093;
    localparam logic [31:0] LW   = 32'h0000A283;
    localparam logic [31:0] ADD6 = 32'h00228333;
    localparam logic [31:0] ILL  = 32'h0000007F;

    initial begin
        reset = 1'b1; if_id_instr = 32'h0; if_id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        step(ADD, 1'b1, 1'b0, 1'b0);
        step(ADD, 1'b1, 1'b0, 1'b0);
        check("rst_valid", 32'(id_ex_valid), 32'd0);
        check("rst_count", 32'(bubble_count), 32'd0);
        check("rst_hazard", 32'(hazard_stall), 32'd0);
        reset = 1'b0;

        step(ADD, 1'b1, 1'b0, 1'b0);
        check("add_aluop", 32'(id_ex_ALUOp), 32'd2);
        check("add_funct", 32'(id_ex_Funct), 32'd0);
        check("add_rd", 32'(id_ex_rd), 32'd3);
        check("add_regwrite", 32'(id_ex_RegWrite), 32'd1);
        step(SUB, 1'b1, 1'b0, 1'b0);
        check("sub_funct", 32'(id_ex_Funct), 32'h8);
        step(BEQ, 1'b1, 1'b0, 1'b0);
        check("beq_aluop", 32'(id_ex_ALUOp), 32'd1);
        check("beq_branch", 32'(id_ex_Branch), 32'd1);
        check("beq_regwrite", 32'(id_ex_RegWrite), 32'd0);
        step(BLT, 1'b1, 1'b0, 1'b0);
        check("blt_funct", 32'(id_ex_Funct), 32'h4);
        step(ADDI, 1'b1, 1'b0, 1'b0);
        check("addi_funct", 32'(id_ex_Funct), 32'h0);
        check("addi_alusrc", 32'(id_ex_ALUSrc), 32'd1);

        // Load-use: one bubble, then the dependent add issues.
        step(LW, 1'b1, 1'b0, 1'b0);
        if_id_instr = ADD6; #1;
        check("lu_hazard", 32'(hazard_stall), 32'd1);
        step(ADD6, 1'b1, 1'b0, 1'b0);
        check("lu_bubble", 32'(id_ex_valid), 32'd0);
        check("lu_count", 32'(bubble_count), 32'd1);
        check("lu_hazard_drop", 32'(hazard_stall), 32'd0);
        step(ADD6, 1'b1, 1'b0, 1'b0);
        check("lu_issue_rd", 32'(id_ex_rd), 32'd6);

        // Illegal opcode, and the same opcode marked invalid.
        if_id_instr = ILL; if_id_valid = 1'b1; #1;
        check("ill_flag", 32'(illegal), 32'd1);
        step(ILL, 1'b1, 1'b0, 1'b0);
        check("ill_valid", 32'(id_ex_valid), 32'd0);
        check("ill_count", 32'(bubble_count), 32'd2);
        if_id_valid = 1'b0; #1;
        check("inv_ill", 32'(illegal), 32'd0);
        step(ILL, 1'b0, 1'b0, 1'b0);
        check("inv_count", 32'(bubble_count), 32'd2);

        // Stall holds; stall with flush bubbles.
        step(ADD, 1'b1, 1'b0, 1'b0);
        step(SUB, 1'b1, 1'b1, 1'b0);
        check("stall_hold", 32'(id_ex_Funct), 32'h0);
        check("stall_valid", 32'(id_ex_valid), 32'd1);
        step(SUB, 1'b1, 1'b1, 1'b1);
        check("flush_stall", 32'(id_ex_valid), 32'd0);

        // Hazard held under stall does not count until released.
        step(LW, 1'b1, 1'b0, 1'b0);
        step(ADD6, 1'b1, 1'b1, 1'b0);
        check("haz_stall_hold", 32'(hazard_stall), 32'd1);
        check("haz_stall_cnt", 32'(bubble_count), 32'd2);
        step(ADD6, 1'b1, 1'b0, 1'b0);
        check("haz_release_cnt", 32'(bubble_count), 32'd3);

        // Reset mid-hazard discards the load and clears the counter.
        step(LW, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        step(ADD6, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        check("rst_mid_valid", 32'(id_ex_valid), 32'd0);
        check("rst_mid_count", 32'(bubble_count), 32'd0);

        // Saturation of the bubble counter.
        for (int i = 0; i < 65540; i++) step(ILL, 1'b1, 1'b0, 1'b0);
        check("sat_count", 32'(bubble_count), 32'h0000FFFF);
        step(ADD, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
